// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit types, port indices, default sizes and
// the per-output allocator state encoding.
package noc_pkg;

    localparam int NP_DEF      = 5;
    localparam int DEPTH_DEF   = 4;
    localparam int PKT_LEN_DEF = 4;
    localparam int LL_DEF      = 16;
    localparam int SEL_W       = 3;

    localparam logic [1:0] FLIT_HEAD   = 2'b00;
    localparam logic [1:0] FLIT_BODY   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_N     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT_CR = 2'b01,
        ST_XFER    = 2'b10
    } alloc_state_e;

    function automatic logic is_last_flit(input logic [1:0] ftype);
        return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NP. One instance serves one router output.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int NP = NP_DEF,
    parameter int IW = SEL_W
) (
    input  logic [NP-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NP-1:0] gnt_o,
    output logic [IW-1:0] idx_o
);

    // scan from the pointer position and stop at the first requester
    always_comb begin
        logic found;
        int   pos;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NP; k++) begin
            pos = (int'(ptr_i) + k) % NP;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per output a round-robin arbiter, credit counter and packet
// lock (IDLE -> WAIT_CR -> XFER) that steers the crossbar until the tail passes.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int NP      = NP_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NP-1:0]       req_i,
    input  logic [SEL_W*NP-1:0] req_out_i,
    input  logic [NP-1:0]       flit_vld_i,
    input  logic [2*NP-1:0]     flit_type_i,
    input  logic [NP-1:0]       credit_ret_i,
    output logic [NP-1:0]       grant_o,
    output logic [NP-1:0]       st_ack_o,
    output logic [SEL_W*NP-1:0] xbar_sel_o,
    output logic [NP-1:0]       xbar_vld_o,
    output logic [NP-1:0]       busy_o,
    output logic [NP-1:0]       cr_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] CR_FULL = CW'(DEPTH);
    localparam logic [FW-1:0] CNT_MAX = FW'(PKT_LEN);

    alloc_state_e     state_q [NP];
    alloc_state_e     state_d [NP];
    logic [SEL_W-1:0] ptr_q   [NP];
    logic [SEL_W-1:0] ptr_d   [NP];
    logic [SEL_W-1:0] sel_q   [NP];
    logic [SEL_W-1:0] sel_d   [NP];
    logic [FW-1:0]    cnt_q   [NP];
    logic [FW-1:0]    cnt_d   [NP];
    logic [CW-1:0]    cr_q    [NP];
    logic [CW-1:0]    cr_d    [NP];

    logic [NP-1:0] grant_q, grant_d;
    logic [NP-1:0] st_ack_q, st_ack_d;
    logic [NP-1:0] busy_q, busy_d;
    logic [NP-1:0] cr_err_q, cr_err_d;
    logic [NP-1:0] xbar_vld_s;

    logic [NP-1:0]    cand_s    [NP];
    logic [NP-1:0]    arb_gnt_s [NP];
    logic [SEL_W-1:0] arb_idx_s [NP];

    // route decode; an out_num >= NP matches no output and is ignored
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                cand_s[o][i] = req_i[i] && (req_out_i[SEL_W*i +: SEL_W] == SEL_W'(o));
            end
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_arb
        rr_arbiter #(.NP(NP), .IW(SEL_W)) u_rr_arbiter (
            .req_i (cand_s[g]),
            .ptr_i (ptr_q[g]),
            .gnt_o (arb_gnt_s[g]),
            .idx_o (arb_idx_s[g])
        );
    end

    // crossbar forwarding, only while the output holds a packet lock
    always_comb begin
        xbar_vld_s = '0;
        xbar_sel_o = '0;
        for (int o = 0; o < NP; o++) begin
            xbar_sel_o[SEL_W*o +: SEL_W] = sel_q[o];
            if (state_q[o] == ST_XFER) begin
                xbar_vld_s[o] = flit_vld_i[sel_q[o]];
            end else begin
                xbar_vld_s[o] = 1'b0;
            end
        end
    end

    // per-output next state, credit accounting and pulse generation
    always_comb begin
        grant_d  = '0;
        st_ack_d = '0;
        busy_d   = '0;
        cr_err_d = cr_err_q;
        for (int o = 0; o < NP; o++) begin
            state_d[o] = state_q[o];
            ptr_d[o]   = ptr_q[o];
            sel_d[o]   = sel_q[o];
            cnt_d[o]   = cnt_q[o];
            cr_d[o]    = cr_q[o];

            // a return and a forward in the same cycle cancel out
            if (credit_ret_i[o] && !xbar_vld_s[o]) begin
                if (cr_q[o] == CR_FULL) begin
                    cr_err_d[o] = 1'b1;
                end else begin
                    cr_d[o] = cr_q[o] + CW'(1);
                end
            end else if (!credit_ret_i[o] && xbar_vld_s[o] && (cr_q[o] != CW'(0))) begin
                cr_d[o] = cr_q[o] - CW'(1);
            end else begin
                cr_d[o] = cr_q[o];
            end

            case (state_q[o])
                ST_IDLE: begin
                    if (|cand_s[o]) begin
                        sel_d[o]   = arb_idx_s[o];
                        grant_d    = grant_d | arb_gnt_s[o];
                        ptr_d[o]   = (arb_idx_s[o] == SEL_W'(NP - 1)) ? SEL_W'(0)
                                                                      : arb_idx_s[o] + SEL_W'(1);
                        state_d[o] = ST_WAIT_CR;
                    end else begin
                        state_d[o] = ST_IDLE;
                    end
                end
                ST_WAIT_CR: begin
                    if (cr_q[o] == CR_FULL) begin
                        st_ack_d[sel_q[o]] = 1'b1;
                        cnt_d[o]           = FW'(0);
                        state_d[o]         = ST_XFER;
                    end else begin
                        state_d[o] = ST_WAIT_CR;
                    end
                end
                ST_XFER: begin
                    if (xbar_vld_s[o]) begin
                        cnt_d[o] = cnt_q[o] + FW'(1);
                        if (is_last_flit(flit_type_i[2*sel_q[o] +: 2]) ||
                            (cnt_q[o] + FW'(1) == CNT_MAX)) begin
                            state_d[o] = ST_IDLE;
                        end else begin
                            state_d[o] = ST_XFER;
                        end
                    end else begin
                        state_d[o] = ST_XFER;
                    end
                end
                default: begin
                    state_d[o] = ST_IDLE;
                end
            endcase

            busy_d[o] = (state_d[o] != ST_IDLE);
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= '0;
            st_ack_q <= '0;
            busy_q   <= '0;
            cr_err_q <= '0;
            for (int o = 0; o < NP; o++) begin
                state_q[o] <= ST_IDLE;
                ptr_q[o]   <= SEL_W'(0);
                sel_q[o]   <= SEL_W'(0);
                cnt_q[o]   <= FW'(0);
                cr_q[o]    <= CR_FULL;
            end
        end else begin
            grant_q  <= grant_d;
            st_ack_q <= st_ack_d;
            busy_q   <= busy_d;
            cr_err_q <= cr_err_d;
            for (int o = 0; o < NP; o++) begin
                state_q[o] <= state_d[o];
                ptr_q[o]   <= ptr_d[o];
                sel_q[o]   <= sel_d[o];
                cnt_q[o]   <= cnt_d[o];
                cr_q[o]    <= cr_d[o];
            end
        end
    end

    assign grant_o    = grant_q;
    assign st_ack_o   = st_ack_q;
    assign busy_o     = busy_q;
    assign cr_err_o   = cr_err_q;
    assign xbar_vld_o = xbar_vld_s;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: single packet, credit stall, round-robin
// fairness, simultaneous credit events, early tail, reset abort, invalid route.
module tb_switch_allocator;
    import noc_pkg::*;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] req;
    logic [3*NP-1:0] req_out;
    logic [NP-1:0] flit_vld;
    logic [2*NP-1:0] flit_type;
    logic [NP-1:0] credit_ret;
    logic [NP-1:0] grant;
    logic [NP-1:0] st_ack;
    logic [3*NP-1:0] xbar_sel;
    logic [NP-1:0] xbar_vld;
    logic [NP-1:0] busy;
    logic [NP-1:0] cr_err;

    int n_pass  = 0;
    int n_total = 0;

    switch_allocator #(.NP(NP), .DEPTH(4), .PKT_LEN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .req_out_i    (req_out),
        .flit_vld_i   (flit_vld),
        .flit_type_i  (flit_type),
        .credit_ret_i (credit_ret),
        .grant_o      (grant),
        .st_ack_o     (st_ack),
        .xbar_sel_o   (xbar_sel),
        .xbar_vld_o   (xbar_vld),
        .busy_o       (busy),
        .cr_err_o     (cr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int win[4] = '{0, 2, 4, 0};

    initial begin
        reset = 1'b1; req = '0; req_out = '0; flit_vld = '0; flit_type = '0; credit_ret = '0;
        tick(); tick();
        check_val("rst_grant",    32'(grant),    32'h0);
        check_val("rst_st_ack",   32'(st_ack),   32'h0);
        check_val("rst_busy",     32'(busy),     32'h0);
        check_val("rst_cr_err",   32'(cr_err),   32'h0);
        check_val("rst_xbar_sel", 32'(xbar_sel), 32'h0);
        check_val("rst_xbar_vld", 32'(xbar_vld), 32'h0);
        reset = 1'b0;
        tick();

        // single packet: input 1 -> output 3
        req_out[5:3] = 3'd3; req[1] = 1'b1;
        tick();
        check_val("s1_grant", 32'(grant), 32'h02);
        check_val("s1_sel3",  32'(xbar_sel[11:9]), 32'h1);
        check_val("s1_busy",  32'(busy), 32'h08);
        req[1] = 1'b0;
        tick();
        check_val("s1_ack",        32'(st_ack), 32'h02);
        check_val("s1_grant_once", 32'(grant),  32'h0);
        for (int k = 0; k < 4; k++) begin
            flit_vld[1] = 1'b1;
            flit_type[3:2] = (k == 0) ? FLIT_HEAD : ((k == 3) ? FLIT_TAIL : FLIT_BODY);
            #1;
            check_val("s1_fwd", 32'(xbar_vld), 32'h08);
            tick();
        end
        flit_vld = '0; flit_type = '0;
        #1;
        check_val("s1_busy_drop", 32'(busy),     32'h0);
        check_val("s1_vld_idle",  32'(xbar_vld), 32'h0);

        // credit stall: output 3 back to 1 credit, input 2 must wait for 3 more
        credit_ret[3] = 1'b1; tick(); credit_ret[3] = 1'b0;
        req_out[8:6] = 3'd3; req[2] = 1'b1;
        tick();
        check_val("cs_grant", 32'(grant), 32'h04);
        req[2] = 1'b0;
        tick(); check_val("cs_hold0", 32'(st_ack), 32'h0);
        tick(); check_val("cs_hold1", 32'(st_ack), 32'h0);
        for (int p = 0; p < 3; p++) begin
            credit_ret[3] = 1'b1; tick(); credit_ret[3] = 1'b0;
            check_val("cs_no_ack", 32'(st_ack), 32'h0);
        end
        tick();
        check_val("cs_ack", 32'(st_ack), 32'h04);
        flit_vld[2] = 1'b1; flit_type[5:4] = FLIT_SINGLE;
        #1;
        check_val("cs_fwd", 32'(xbar_vld), 32'h08);
        tick();
        flit_vld = '0; flit_type = '0;
        check_val("cs_done", 32'(busy), 32'h0);
        credit_ret[3] = 1'b1; tick(); credit_ret[3] = 1'b0;
        check_val("cs_no_err", 32'(cr_err), 32'h0);

        // contention on output 1 from inputs 0, 2, 4; credits returned with each flit
        req_out[2:0] = 3'd1; req_out[8:6] = 3'd1; req_out[14:12] = 3'd1;
        req = 5'b10101;
        for (int p = 0; p < 4; p++) begin
            tick();
            check_val("rr_grant", 32'(grant), 32'(1) << win[p]);
            check_val("rr_sel",   32'(xbar_sel[5:3]), 32'(win[p]));
            tick();
            check_val("rr_ack", 32'(st_ack), 32'(1) << win[p]);
            for (int k = 0; k < 4; k++) begin
                flit_vld[win[p]] = 1'b1;
                flit_type[2*win[p] +: 2] = (k == 0) ? FLIT_HEAD : FLIT_BODY;
                credit_ret[1] = 1'b1;
                #1;
                check_val("rr_fwd", 32'(xbar_vld), 32'h02);
                tick();
                flit_vld = '0; flit_type = '0; credit_ret = '0;
            end
        end
        req = '0;
        tick();
        check_val("rr_idle",   32'(busy),   32'h0);
        check_val("rr_no_err", 32'(cr_err), 32'h0);

        // simultaneous return and forward on output 4, then overflow
        req_out[2:0] = 3'd4; req[0] = 1'b1;
        tick(); check_val("sim_grant", 32'(grant), 32'h01);
        req[0] = 1'b0;
        tick(); check_val("sim_ack", 32'(st_ack), 32'h01);
        flit_vld[0] = 1'b1; flit_type[1:0] = FLIT_SINGLE; credit_ret[4] = 1'b1;
        #1;
        check_val("sim_fwd", 32'(xbar_vld), 32'h10);
        tick();
        flit_vld = '0; flit_type = '0; credit_ret = '0;
        check_val("sim_err_clear", 32'(cr_err), 32'h0);
        credit_ret[4] = 1'b1; tick(); credit_ret[4] = 1'b0;
        check_val("sim_err_set", 32'(cr_err), 32'h10);
        tick(); tick();
        check_val("sim_err_sticky", 32'(cr_err), 32'h10);

        // early tail on output 2: HEAD+TAIL from input 3, input 1 waiting
        req_out[11:9] = 3'd2; req = 5'b01000;
        tick(); check_val("et_grant3", 32'(grant), 32'h08);
        req_out[5:3] = 3'd2; req = 5'b00010;
        tick();
        check_val("et_ack3",    32'(st_ack), 32'h08);
        check_val("et_locked",  32'(grant),  32'h0);
        flit_vld[3] = 1'b1; flit_type[7:6] = FLIT_HEAD; credit_ret[2] = 1'b1;
        #1; check_val("et_fwd_head", 32'(xbar_vld), 32'h04);
        tick();
        check_val("et_busy", 32'(busy), 32'h04);
        flit_type[7:6] = FLIT_TAIL;
        #1; check_val("et_fwd_tail", 32'(xbar_vld), 32'h04);
        tick();
        flit_vld = '0; flit_type = '0; credit_ret = '0;
        check_val("et_released", 32'(busy), 32'h0);
        tick();
        check_val("et_grant1", 32'(grant), 32'h02);
        req = '0;
        tick(); check_val("et_ack1", 32'(st_ack), 32'h02);
        flit_vld[1] = 1'b1; flit_type[3:2] = FLIT_HEAD;
        #1; check_val("et_fwd1", 32'(xbar_vld), 32'h04);
        tick();
        flit_vld = '0; flit_type = '0;

        // reset mid-packet (output 2 in XFER with 3 credits)
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("mr_grant",    32'(grant),    32'h0);
        check_val("mr_st_ack",   32'(st_ack),   32'h0);
        check_val("mr_busy",     32'(busy),     32'h0);
        check_val("mr_cr_err",   32'(cr_err),   32'h0);
        check_val("mr_xbar_sel", 32'(xbar_sel), 32'h0);
        flit_vld[1] = 1'b1;
        #1; check_val("mr_xbar_vld", 32'(xbar_vld), 32'h0);
        flit_vld = '0;
        req[1] = 1'b1;
        tick(); check_val("mr_regrant", 32'(grant), 32'h02);
        req = '0;
        tick(); check_val("mr_full_credit", 32'(st_ack), 32'h02);
        flit_vld[1] = 1'b1; flit_type[3:2] = FLIT_SINGLE;
        tick();
        flit_vld = '0; flit_type = '0;

        // invalid route never wins
        req_out[14:12] = 3'd6; req = 5'b10000;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_val("inv_grant", 32'(grant), 32'h0);
            check_val("inv_busy",  32'(busy),  32'h0);
        end
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
